id_ex_control_stage: RTL

- ID-stage decoder and ID/EX pipeline register. It turns the 32-bit MIPS instruction held in IF/ID into the registered control bundle that drives the EX-stage ALU: ALUOp, function select, shift amount, branch sense and operands.
- It also detects load-use hazards. On a hazard it raises a stall and inserts a bubble.
- It honours a branch flush coming back from EX/MEM.
- It sits between the IF/ID register / register file and the EX stage (forwarding muxes, ALU).

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/id_control_decode.sv | 84 ++++++++
 rtl/id_ex_control_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants and control-bundle widths
package mips_pkg;

    localparam int ALUOP_W = 2;
    localparam int FUNCT_W = 6;
    localparam int SA_W    = 5;

    localparam logic [ALUOP_W-1:0] ALUOP_LS = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RI = 2'b10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    function automatic logic funct_supported(input logic [5:0] funct);
        case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SRLV, FN_SRAV, FN_ADDU,
            FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_control_decode.sv
// rtl/id_control_decode.sv - combinational opcode/funct to control-bundle decode
module id_control_decode
    import mips_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [REG_AW-1:0]  rt,
    input  logic [REG_AW-1:0]  rd,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [FUNCT_W-1:0] inst_reg,
    output logic [REG_AW-1:0]  wr_reg,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               branch,
    output logic               flag_branch,
    output logic               reads_rt,
    output logic               illegal
);

    always_comb begin
        alu_op      = ALUOP_LS;
        inst_reg    = '0;
        wr_reg      = '0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        branch      = 1'b0;
        flag_branch = 1'b0;
        reads_rt    = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reads_rt = 1'b1;
                if (funct_supported(funct)) begin
                    alu_op    = ALUOP_RI;
                    inst_reg  = funct;
                    reg_write = 1'b1;
                    wr_reg    = rd;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                wr_reg     = rt;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                reads_rt  = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                alu_op      = ALUOP_BR;
                branch      = 1'b1;
                flag_branch = (opcode == OP_BEQ);
                reads_rt    = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                alu_op    = ALUOP_RI;
                inst_reg  = opcode;
                alu_src   = 1'b1;
                reg_write = 1'b1;
                wr_reg    = rt;
            end
            default: illegal = 1'b1;
        endcase
        // $0 is hardwired, so a write to it is dropped here rather than in WB
        if (wr_reg == '0) begin
            reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_control_stage.sv
// rtl/id_ex_control_stage.sv - ID decode, load-use hazard detect and ID/EX register
module id_ex_control_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  instr_i,
    input  logic               instr_valid_i,
    input  logic [DATA_W-1:0]  pc_plus4_i,
    input  logic [DATA_W-1:0]  rd_data_a_i,
    input  logic [DATA_W-1:0]  rd_data_b_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [FUNCT_W-1:0] inst_reg_o,
    output logic [SA_W-1:0]    sa_o,
    output logic               flag_branch_o,
    output logic [DATA_W-1:0]  data_a_o,
    output logic [DATA_W-1:0]  data_b_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [REG_AW-1:0]  rs_o,
    output logic [REG_AW-1:0]  rt_o,
    output logic [REG_AW-1:0]  rd_o,
    output logic [REG_AW-1:0]  wr_reg_o,
    output logic               reg_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_to_reg_o,
    output logic               alu_src_o,
    output logic               branch_o,
    output logic [DATA_W-1:0]  pc_plus4_o,
    output logic               illegal_o
);

    logic [REG_AW-1:0]  rs, rt, rd;
    logic [ALUOP_W-1:0] dec_alu_op;
    logic [FUNCT_W-1:0] dec_inst_reg;
    logic [REG_AW-1:0]  dec_wr_reg;
    logic dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
    logic dec_alu_src, dec_branch, dec_flag_branch, dec_reads_rt, dec_illegal;
    logic hazard, issue;

    assign rs = instr_i[25:21];
    assign rt = instr_i[20:16];
    assign rd = instr_i[15:11];

    id_control_decode #(.REG_AW(REG_AW)) u_decode (
        .opcode      (instr_i[31:26]),
        .funct       (instr_i[5:0]),
        .rt          (rt),
        .rd          (rd),
        .alu_op      (dec_alu_op),
        .inst_reg    (dec_inst_reg),
        .wr_reg      (dec_wr_reg),
        .reg_write   (dec_reg_write),
        .mem_read    (dec_mem_read),
        .mem_write   (dec_mem_write),
        .mem_to_reg  (dec_mem_to_reg),
        .alu_src     (dec_alu_src),
        .branch      (dec_branch),
        .flag_branch (dec_flag_branch),
        .reads_rt    (dec_reads_rt),
        .illegal     (dec_illegal)
    );

    // The load in EX is visible through the registered bundle; the bubble it
    // causes clears mem_read_o, so a stall can never repeat next cycle.
    assign hazard = mem_read_o && (wr_reg_o != '0) && instr_valid_i &&
                    ((rs == wr_reg_o) || (dec_reads_rt && (rt == wr_reg_o)));
    assign stall_o = hazard && !flush_i && !reset;
    assign issue   = instr_valid_i && !flush_i && !hazard;

    always_ff @(posedge clk) begin
        if (reset || !issue || dec_illegal) begin
            alu_op_o      <= ALUOP_LS;
            inst_reg_o    <= '0;
            sa_o          <= '0;
            flag_branch_o <= 1'b0;
            data_a_o      <= '0;
            data_b_o      <= '0;
            imm_o         <= '0;
            rs_o          <= '0;
            rt_o          <= '0;
            rd_o          <= '0;
            wr_reg_o      <= '0;
            reg_write_o   <= 1'b0;
            mem_read_o    <= 1'b0;
            mem_write_o   <= 1'b0;
            mem_to_reg_o  <= 1'b0;
            alu_src_o     <= 1'b0;
            branch_o      <= 1'b0;
            pc_plus4_o    <= '0;
            illegal_o     <= !reset && issue && dec_illegal;
        end else begin
            alu_op_o      <= dec_alu_op;
            inst_reg_o    <= dec_inst_reg;
            sa_o          <= instr_i[10:6];
            flag_branch_o <= dec_flag_branch;
            data_a_o      <= rd_data_a_i;
            data_b_o      <= rd_data_b_i;
            imm_o         <= {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};
            rs_o          <= rs;
            rt_o          <= rt;
            rd_o          <= rd;
            wr_reg_o      <= dec_wr_reg;
            reg_write_o   <= dec_reg_write;
            mem_read_o    <= dec_mem_read;
            mem_write_o   <= dec_mem_write;
            mem_to_reg_o  <= dec_mem_to_reg;
            alu_src_o     <= dec_alu_src;
            branch_o      <= dec_branch;
            pc_plus4_o    <= pc_plus4_i;
            illegal_o     <= 1'b0;
        end
    end

endmodule
